// File: rtl/fetch_pkg.sv
// Shared state encoding, constants and entry type for the fetch redirect unit.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  // Counter must hold the value MAX_OUTSTANDING itself, hence the +1.
  function automatic int outstanding_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  localparam int DEFAULT_OUTSTANDING_W = outstanding_width(2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Bundles the imem request/response, redirect and decode handshakes of the fetch unit.
interface fetch_redirect_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_target,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output misalign
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_target,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  misalign
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} buffer between imem responses and decode; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Storage is cleared on reset so the decode outputs read zero rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: in-order imem requests, response buffering and redirect flush.
// Optional FETCH_PERF_EN adds redirect and dropped-response counters.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_discards
`endif
);

  localparam int OW = outstanding_width(MAX_OUTSTANDING);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] discard;
  logic          misalign_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          room;
  logic          target_aligned;
  logic [31:0]   target_pc;

  assign target_pc      = bus.redirect_target & ALIGN_MASK;
  assign target_aligned = (bus.redirect_target[1:0] == 2'b00);

  assign rsp_drop = bus.imem_rsp_valid && (discard != '0);
  assign rsp_keep = bus.imem_rsp_valid && (discard == '0);

  // Live (non-discarded) requests already own a FIFO slot, so count them against capacity.
  assign room = (int'(fifo_count) + int'(outstanding) - int'(discard)) < FIFO_DEPTH;

  assign bus.imem_req_valid = !rst && (state == RUN) && !bus.redirect_valid &&
                              (int'(outstanding) < MAX_OUTSTANDING) && room;
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign fifo_push  = rsp_keep;
  assign fifo_pop   = !fifo_empty && bus.id_ready;
  assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  assign bus.id_valid = !fifo_empty;
  assign bus.id_pc    = fifo_head.pc;
  assign bus.id_instr = fifo_head.instr;
  assign bus.misalign = misalign_q;

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !bus.imem_rsp_valid) begin
      outstanding_nxt = outstanding + OW'(1);
    end else if (!req_fire && bus.imem_rsp_valid) begin
      outstanding_nxt = outstanding - OW'(1);
    end
  end

  // A redirect retargets both PCs and marks every still-outstanding request as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        fetch_pc   <= target_pc;
        rsp_pc     <= target_pc;
        discard    <= outstanding_nxt;
        misalign_q <= !target_aligned;
        state      <= target_aligned ? RUN : HALT;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        end
        if (rsp_drop) begin
          discard <= discard - OW'(1);
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'(INSTR_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fifo_push && !bus.redirect_valid && !fifo_pop) begin
      assert (!fifo_full);
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (bus.redirect_valid),
    .push_data(push_entry),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects <= '0;
      perf_discards  <= '0;
    end else begin
      if (bus.redirect_valid) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (rsp_drop) begin
        perf_discards <= perf_discards + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: in-order memory model plus a queue-based reference.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RESET_PC        = 32'h0000_0100;
  localparam int          FIFO_DEPTH      = 4;
  localparam int          MAX_OUTSTANDING = 2;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic clk = 1'b0;
  logic rst;

  fetch_redirect_unit_if bus_if();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_discards;
`endif

  fetch_redirect_unit #(
    .RESET_PC       (RESET_PC),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_discards (perf_discards)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;

  flight_t     m_inflight[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_fetch_pc;
  bit          m_halt;
  bit          m_misalign;
  mem_req_t    mem_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];

  bit          s_fire_exp;
  bit          s_pop_exp;
  bit          s_dut_fire;
  logic [31:0] s_dut_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1000;
  endfunction

  function automatic int liveCount();
    int n = 0;
    foreach (m_inflight[i]) if (!m_inflight[i].stale) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resetModel();
    m_inflight.delete();
    m_fifo.delete();
    m_fetch_pc = RESET_PC;
    m_halt     = 1'b0;
    m_misalign = 1'b0;
  endtask

  // Compare every output against the reference model, then record this cycle's handshakes.
  task automatic checkOutput();
    logic exp_valid;
    exp_valid = !rst && !m_halt && !bus_if.redirect_valid &&
                (m_inflight.size() < MAX_OUTSTANDING) &&
                ((m_fifo.size() + liveCount()) < FIFO_DEPTH);
    check("req_valid", 32'(bus_if.imem_req_valid), 32'(exp_valid));
    if (exp_valid) check("req_addr", bus_if.imem_req_addr, m_fetch_pc);
    check("id_valid", 32'(bus_if.id_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("id_pc", bus_if.id_pc, m_fifo[0]);
      check("id_instr", bus_if.id_instr, instr_of(m_fifo[0]));
    end
    check("misalign", 32'(bus_if.misalign), 32'(m_misalign));
    check("no_x", 32'($isunknown({bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.id_valid,
                                  bus_if.id_pc, bus_if.id_instr, bus_if.misalign})), 32'd0);
    s_fire_exp = exp_valid && bus_if.imem_req_ready;
    s_pop_exp  = (m_fifo.size() > 0) && bus_if.id_ready;
    s_dut_fire = (bus_if.imem_req_valid === 1'b1) && bus_if.imem_req_ready;
    s_dut_addr = bus_if.imem_req_addr;
    if (s_dut_fire) req_log.push_back(bus_if.imem_req_addr);
    if ((bus_if.id_valid === 1'b1) && bus_if.id_ready) pop_log.push_back(bus_if.id_pc);
  endtask

  task automatic updateModel();
    flight_t f;
    cyc++;
    if (rst) begin
      resetModel();
      mem_q.delete();
    end else begin
      if (s_pop_exp) m_fifo.delete(0);
      if (bus_if.imem_rsp_valid) begin
        if (mem_q.size() > 0) mem_q.delete(0);
        if (m_inflight.size() > 0) begin
          f = m_inflight[0];
          m_inflight.delete(0);
          if (!f.stale) m_fifo.push_back(f.pc);
        end
      end
      if (s_fire_exp) begin
        m_inflight.push_back('{pc: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (bus_if.redirect_valid) begin
        m_fifo.delete();
        foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
        m_fetch_pc = {bus_if.redirect_target[31:2], 2'b00};
        m_misalign = (bus_if.redirect_target[1:0] != 2'b00);
        m_halt     = m_misalign;
      end
      if (s_dut_fire) mem_q.push_back('{addr: s_dut_addr, due: cyc + mem_lat - 1});
    end
  endtask

  task automatic driveMemory();
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
    driveMemory();
  endtask

  task automatic applyStimulus(input bit req_ready, input bit dec_ready);
    bus_if.imem_req_ready = req_ready;
    bus_if.id_ready       = dec_ready;
  endtask

  task automatic doRedirect(input logic [31:0] target);
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = target;
    runCycle();
    bus_if.redirect_valid  = 1'b0;
  endtask

  task automatic waitPop(input string name, input logic [31:0] exp_pc);
    int n = 0;
    pop_log.delete();
    while ((pop_log.size() == 0) && (n < 30)) begin
      runCycle();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 30), 32'd1);
    if (pop_log.size() > 0) check(name, pop_log[0], exp_pc);
  endtask

  initial begin
    int n;
    rst                    = 1'b1;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_target = '0;
    bus_if.imem_rsp_valid  = 1'b0;
    bus_if.imem_rsp_data   = '0;
    applyStimulus(1'b1, 1'b1);
    resetModel();
    @(posedge clk);
    updateModel();
    #1;
    driveMemory();
    #1;
    check("rst_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(bus_if.id_valid), 32'd0);
    check("rst_id_pc", bus_if.id_pc, 32'd0);
    check("rst_id_instr", bus_if.id_instr, 32'd0);
    check("rst_misalign", 32'(bus_if.misalign), 32'd0);
    runCycle();
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    check("first_req_addr", bus_if.imem_req_addr, 32'h0000_0100);

    // Streaming with a one-cycle memory and an always-ready decoder.
    repeat (8) runCycle();
    check("stream_req0", req_log[0], 32'h0000_0100);
    check("stream_req1", req_log[1], 32'h0000_0104);
    check("stream_req2", req_log[2], 32'h0000_0108);
    check("stream_pop0", pop_log[0], 32'h0000_0100);
    check("stream_pop1", pop_log[1], 32'h0000_0104);
    check("stream_pop2", pop_log[2], 32'h0000_0108);

    // Decode stall fills the buffer; drain it with no new fetches.
    applyStimulus(1'b1, 1'b0);
    repeat (10) runCycle();
    #1;
    check("stall_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    check("stall_id_valid", 32'(bus_if.id_valid), 32'd1);
    applyStimulus(1'b0, 1'b1);
    pop_log.delete();
    repeat (8) runCycle();
    check("stall_pop_count", 32'(pop_log.size()), 32'd4);
    check("stall_pop_span", pop_log[3] - pop_log[0], 32'd12);

    // Request held while imem is not ready.
    doRedirect(32'h0000_5000);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
      check("hold_req_addr", bus_if.imem_req_addr, 32'h0000_5000);
      runCycle();
    end
    applyStimulus(1'b1, 1'b1);
    waitPop("hold_first_pop", 32'h0000_5000);

    // Redirect with two requests in flight on a slower memory.
    mem_lat = 3;
    n = 0;
    while (!((m_inflight.size() == 2) && !bus_if.imem_rsp_valid) && (n < 30)) begin
      runCycle();
      n++;
    end
    check("two_outstanding_timeout", 32'(n < 30), 32'd1);
    doRedirect(32'h0000_2000);
    waitPop("discard_first_pop", 32'h0000_2000);

    // Misaligned redirect halts fetch until an aligned one arrives.
    mem_lat = 1;
    doRedirect(32'h0000_2002);
    #1;
    check("mis_flag", 32'(bus_if.misalign), 32'd1);
    for (int i = 0; i < 5; i++) begin
      runCycle();
      #1;
      check("halt_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    end
    doRedirect(32'h0000_3000);
    #1;
    check("mis_clear", 32'(bus_if.misalign), 32'd0);
    check("resume_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    check("resume_req_addr", bus_if.imem_req_addr, 32'h0000_3000);
    waitPop("resume_first_pop", 32'h0000_3000);

    // Redirect coinciding with a response and a decode pop.
    n = 0;
    while (!(bus_if.imem_rsp_valid && (m_fifo.size() > 0)) && (n < 30)) begin
      runCycle();
      n++;
    end
    check("collide_timeout", 32'(n < 30), 32'd1);
    doRedirect(32'h0000_4000);
    #1;
    check("collide_id_valid", 32'(bus_if.id_valid), 32'd0);
    check("collide_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    check("collide_req_addr", bus_if.imem_req_addr, 32'h0000_4000);
    waitPop("collide_first_pop", 32'h0000_4000);

    // Back-to-back redirects: the second target wins.
    bus_if.redirect_valid  = 1'b1;
    bus_if.redirect_target = 32'h0000_6000;
    runCycle();
    bus_if.redirect_target = 32'h0000_7000;
    runCycle();
    bus_if.redirect_valid  = 1'b0;
    #1;
    check("b2b_req_addr", bus_if.imem_req_addr, 32'h0000_7000);
    waitPop("b2b_first_pop", 32'h0000_7000);

    repeat (10) runCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
